// File: rtl/bus_hs_pkg.sv
// Shared constants and state encoding for the bus_hs family of handshake blocks.
package bus_hs_pkg;

    localparam int unsigned BusDataWidth  = 8;
    localparam int unsigned BusNumMasters = 4;
    localparam int unsigned BusIdWidth    = 2;

    // Output register occupancy: EMPTY holds no beat, FULL holds one beat.
    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } hs_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first requesting index at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    logic [IW:0]   sum;
    logic [IW-1:0] pos;

    // Scan ptr, ptr+1, ... and keep only the first hit.
    always_comb begin
        any = 1'b0;
        idx = '0;
        sum = '0;
        pos = '0;
        for (int unsigned k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            pos = sum[IW-1:0];
            if (!any && req[pos]) begin
                any = 1'b1;
                idx = pos;
            end
        end
    end

endmodule

// File: rtl/rr_bus_arbiter.sv
// N-master round-robin arbiter onto a single registered valid/ready slave port.
module rr_bus_arbiter
    import bus_hs_pkg::*;
#(
    parameter int unsigned L  = BusDataWidth,
    parameter int unsigned N  = BusNumMasters,
    parameter int unsigned IW = BusIdWidth
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   m_valid,
    input  logic [N*L-1:0] m_data,
    output logic [N-1:0]   m_ready,
    output logic           s_valid,
    output logic [L-1:0]   s_data,
    output logic [IW-1:0]  s_id,
    input  logic           s_ready
);

    hs_state_e     state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [L-1:0]  data_q;
    logic [IW-1:0] id_q;

    logic          any;
    logic [IW-1:0] winner;
    logic          load_en;
    logic          m_xfer;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_rr_pick (
        .req (m_valid),
        .ptr (ptr_q),
        .any (any),
        .idx (winner)
    );

    assign s_valid = (state_q == StFull);
    assign s_data  = data_q;
    assign s_id    = id_q;

    // The register can take a new beat when empty or when it is draining this cycle.
    assign load_en = !s_valid || s_ready;
    assign m_xfer  = any && load_en;

    // One-hot accept to the winner; held low while in reset.
    always_comb begin
        m_ready = '0;
        if (rst && m_xfer) begin
            m_ready[winner] = 1'b1;
        end
    end

    // Pointer advances past the winner on every accepted beat.
    always_comb begin
        ptr_d = ptr_q;
        if (m_xfer) begin
            ptr_d = (winner == IW'(N - 1)) ? '0 : winner + IW'(1);
        end
    end

    // Occupancy next-state: fill on any request, drain on s_ready with nothing to refill.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (any) state_d = StFull;
            StFull:  if (s_ready && !any) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    // State, pointer and beat registers; reset discards any held beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StEmpty;
            ptr_q   <= '0;
            data_q  <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (m_xfer) begin
                data_q <= m_data[winner*L +: L];
                id_q   <= winner;
            end
        end
    end

endmodule

// File: doc/rr_bus_arbiter.md
RR_BUS_ARBITER -- requirements
Module: rr_bus_arbiter

Interface
REQ-001 Parameter L, default 8, is the data width of every master and of the slave port.
REQ-002 Parameter N, default 4, is the number of requesting masters (2..16).
REQ-003 Parameter IW, default 2, is the grant-ID width and SHALL equal clog2(N).
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 m_valid  input  N  per-master request; bit i asserts that m_data slice i is valid.
REQ-007 m_data  input  N*L  packed master data; slice i is bits [i*L+L-1 : i*L].
REQ-008 m_ready  output  N  per-master accept; at most one bit is high in any cycle.
REQ-009 s_valid  output  1  slave-side valid, driven from a register.
REQ-010 s_data  output  L  slave-side data, driven from a register.
REQ-011 s_id  output  IW  index of the master whose beat currently sits on s_data.
REQ-012 s_ready  input  1  slave accept.

Function
REQ-013 A transfer on either side SHALL occur only in a cycle where valid and ready are both high.
REQ-014 load_en SHALL equal (!s_valid || s_ready); it is combinational.
REQ-015 The winner SHALL be the first index i with m_valid[i]=1, searching ptr, ptr+1, ... ptr+N-1 (mod N).
REQ-016 m_ready[winner] SHALL equal load_en when any m_valid is high; all other m_ready bits SHALL be 0.
  - m_ready SHALL depend only on m_valid, ptr, s_valid and s_ready.
REQ-017 On a master transfer, the block SHALL load s_data with the winner's slice and s_id with the winner, and SHALL set s_valid=1, giving one-cycle latency.
REQ-018 On a master transfer, ptr SHALL become winner+1, wrapping from N-1 to 0; otherwise ptr SHALL hold.
REQ-019 On a slave transfer with no simultaneous master transfer, s_valid SHALL clear; s_data and s_id SHALL hold.
REQ-020 Simultaneous slave and master transfers in one cycle SHALL reload the register with the new beat.
  - This sustains 1 beat/cycle with no bubble.
REQ-021 While s_valid=1 and s_ready=0, s_valid, s_data and s_id SHALL remain stable and no m_ready bit SHALL assert.
REQ-022 The two states are EMPTY (s_valid=0) and FULL (s_valid=1).
  - EMPTY->FULL on any m_valid.
  - FULL->EMPTY on s_ready with no m_valid.
  - FULL->FULL on s_ready with any m_valid, or on !s_ready.
REQ-023 Fairness: with all N masters continuously requesting and s_ready=1, each master SHALL be granted exactly once in every N consecutive transfers.
REQ-024 A master that drops m_valid before being accepted SHALL lose nothing.
  - The block SHALL never have latched that master's data.

Reset
REQ-025 Asserting rst low SHALL immediately force s_valid=0, s_data=0, s_id=0 and ptr=0, independent of clk.
  - Assertion mid-operation SHALL discard any held beat.
REQ-026 While rst is low, m_ready SHALL be all zero.
REQ-027 The first transfer after deassertion SHALL occur no earlier than the first rising edge of clk with rst high.
  - With all masters requesting at that point, the first beat SHALL be master 0.

Structure
REQ-028 Shared package bus_hs_pkg SHALL hold the default L, N and IW constants and the EMPTY/FULL state encoding.
  - Other handshake blocks in the bus_hs family reuse them.
REQ-029 The round-robin search SHALL live in one combinational sub-module, rr_pick.
  - Inputs: req[N], ptr[IW].
  - Outputs: any, idx[IW].
REQ-030 The implementation SHALL be synthesizable, with no latches and no combinational path from s_data-side registers back into m_ready other than through s_valid.

Verification
REQ-031 Single request: m_valid=0100, m_data slice 2=8'hA5, s_ready=1 -> m_ready=0100 for one cycle; next cycle s_valid=1, s_data=A5, s_id=2, ptr=3.
REQ-032 Full contention: m_valid=1111 held, s_ready=1, slices 11/22/33/44 -> s_id sequence 0,1,2,3,0,1...; data matches slices; one beat per cycle.
REQ-033 Backpressure: FULL with s_data=8'h3C, s_ready=0 for 5 cycles -> s_data, s_valid and s_id stable; m_ready=0000 throughout; s_ready=1 releases 3C.
REQ-034 Pointer wrap: ptr=3, m_valid=1001 -> master 3 wins first, then ptr=0 and master 0 wins next.
REQ-035 Reset mid-transfer: rst low while FULL and s_ready=0 -> s_valid=0 within the same cycle (asynchronous); after release with m_valid=1111, master 0 is granted first.
REQ-036 Withdrawn request: m_valid bit 1 pulses for one cycle while FULL with s_ready=0 -> master 1 is never granted; no beat with s_id=1 appears.
